// File: rtl/uart_receiver.sv
// UART receiver: configurable 5-8 data bits, optional parity, break and framing detection.
// rx is synchronized and sampled mid-bit; results are latched with a single-cycle po_flag.
module uart_receiver (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  input  logic [1:0]  word_length,
  input  logic [15:0] baud_rate_cnt,
  input  logic        parity_en,
  input  logic        even_parity,
  output logic [7:0]  po_rx_data,
  output logic        po_flag,
  output logic        po_parity_err,
  output logic        po_frame_err,
  output logic        po_break
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t      state_reg, state_next;
  logic        rx_meta_reg, rx_s_reg, rx_prev_reg;
  logic [1:0]  sync_vld_reg;
  logic [15:0] baud_cnt_reg, cfg_baud_reg;
  logic [2:0]  bit_cnt_reg, cfg_last_bit_reg;
  logic        cfg_par_en_reg, cfg_even_reg;
  logic [7:0]  data_reg;
  logic        par_bit_reg, all_zero_reg;
  logic        start_edge, strobe, last_bit, leave_idle;

  // rx_prev only follows rx_s once the synchronizer holds real line samples,
  // so the reset value of the flops can never fake a falling edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_reg  <= 1'b1;
      rx_s_reg     <= 1'b1;
      rx_prev_reg  <= 1'b0;
      sync_vld_reg <= 2'b00;
    end else begin
      rx_meta_reg  <= rx;
      rx_s_reg     <= rx_meta_reg;
      sync_vld_reg <= {sync_vld_reg[0], 1'b1};
      rx_prev_reg  <= sync_vld_reg[1] ? rx_s_reg : 1'b0;
    end
  end

  assign start_edge = rx_prev_reg & ~rx_s_reg;

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start_edge) state_next = START;
      START:   if (strobe) state_next = rx_s_reg ? IDLE : DATA;
      DATA:    if (strobe && last_bit) state_next = cfg_par_en_reg ? PARITY : STOP;
      PARITY:  if (strobe) state_next = STOP;
      STOP:    if (strobe) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    strobe     = (state_reg != IDLE) && (baud_cnt_reg == (cfg_baud_reg >> 1));
    last_bit   = (bit_cnt_reg == cfg_last_bit_reg);
    leave_idle = (state_reg == IDLE) && start_edge;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      baud_cnt_reg     <= '0;
      bit_cnt_reg      <= '0;
      cfg_baud_reg     <= '0;
      cfg_last_bit_reg <= '0;
      cfg_par_en_reg   <= 1'b0;
      cfg_even_reg     <= 1'b0;
      data_reg         <= '0;
      par_bit_reg      <= 1'b0;
      all_zero_reg     <= 1'b0;
      po_rx_data       <= '0;
      po_flag          <= 1'b0;
      po_parity_err    <= 1'b0;
      po_frame_err     <= 1'b0;
      po_break         <= 1'b0;
    end else begin
      po_flag <= 1'b0;

      if (state_reg == IDLE)                baud_cnt_reg <= '0;
      else if (baud_cnt_reg == cfg_baud_reg) baud_cnt_reg <= '0;
      else                                   baud_cnt_reg <= baud_cnt_reg + 16'd1;

      // Configuration is frozen for the whole frame at the start edge.
      if (leave_idle) begin
        cfg_baud_reg     <= baud_rate_cnt;
        cfg_last_bit_reg <= 3'(3'd4 + {1'b0, word_length});
        cfg_par_en_reg   <= parity_en;
        cfg_even_reg     <= even_parity;
        data_reg         <= '0;
        bit_cnt_reg      <= '0;
        par_bit_reg      <= 1'b0;
        all_zero_reg     <= 1'b1;
      end

      if (strobe) begin
        case (state_reg)
          DATA: begin
            data_reg[bit_cnt_reg] <= rx_s_reg;
            all_zero_reg          <= all_zero_reg & ~rx_s_reg;
            bit_cnt_reg           <= last_bit ? 3'd0 : bit_cnt_reg + 3'd1;
          end
          PARITY: begin
            par_bit_reg  <= rx_s_reg;
            all_zero_reg <= all_zero_reg & ~rx_s_reg;
          end
          STOP: begin
            po_flag       <= 1'b1;
            po_rx_data    <= data_reg;
            po_frame_err  <= ~rx_s_reg;
            po_break      <= all_zero_reg & ~rx_s_reg;
            po_parity_err <= cfg_par_en_reg & (^data_reg ^ par_bit_reg ^ ~cfg_even_reg);
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous, active-high reset; sampled on the rising edge of clk.
REQ-004 rx  input  1  asynchronous serial line; idles high.
REQ-005 word_length  input  2  data bits: 0=5, 1=6, 2=7, 3=8.
REQ-006 baud_rate_cnt  input  16  bit period in clocks, minus one; the bit period is baud_rate_cnt+1 clocks.
REQ-007 parity_en  input  1  1 = one parity bit follows the data.
REQ-008 even_parity  input  1  1 = even parity expected, 0 = odd; ignored when parity_en=0.
REQ-009 po_rx_data  output  8  received word, LSB first on the line; unused upper bits are 0.
REQ-010 po_flag  output  1  one-clock pulse; po_rx_data and the error outputs are valid in that cycle.
REQ-011 po_parity_err  output  1  parity mismatch for the current word.
REQ-012 po_frame_err  output  1  stop bit sampled low.
REQ-013 po_break  output  1  whole frame held low (start, data, parity and stop all 0).

Function
REQ-014 rx SHALL pass through a two-flop synchronizer; all logic SHALL use the synchronized value (rx_s).
REQ-015 The state machine SHALL have the states IDLE, START, DATA, PARITY and STOP.
REQ-016 IDLE -> START: on a 1-to-0 transition of rx_s; the baud counter clears to 0.
REQ-017 Baud counter: counts 0..baud_rate_cnt, then wraps to 0; it is held at 0 in IDLE.
REQ-018 Sample strobe: one clock when baud_cnt == baud_rate_cnt>>1 (mid-bit).
REQ-019 START:
  - strobe with rx_s=1 -> false start; return to IDLE with no output pulse.
  - strobe with rx_s=0 -> go to DATA.
REQ-020 DATA:
  - each strobe shifts rx_s into data bit index bit_cnt, LSB first.
  - after 5+word_length bits, go to PARITY if parity_en=1, otherwise to STOP.
REQ-021 PARITY: on the strobe, capture the parity bit.
  - po_parity_err = 1 when the XOR of the data bits and the parity bit is not 0 (even) or not 1 (odd).
  - then go to STOP.
REQ-022 STOP: on the strobe of the first stop bit only:
  - po_flag = 1 in the next cycle; the FSM returns to IDLE in that same cycle.
  - no second stop bit is checked (the transmitter's 2-stop setting is tolerated).
REQ-023 po_frame_err SHALL be 1 when the stop sample is 0.
REQ-024 po_break SHALL be 1 when the start, data, parity and stop samples are all 0.
  - po_frame_err is also 1 in that case; po_rx_data = 0.
REQ-025 After a break, IDLE SHALL NOT accept a new start until rx_s has been high for at least one clock.
REQ-026 po_rx_data, po_parity_err, po_frame_err and po_break SHALL hold their values until the next po_flag.
REQ-027 po_parity_err SHALL be 0 when parity_en=0.
REQ-028 Configuration inputs SHALL be sampled when leaving IDLE and held for the rest of the frame; a mid-frame change SHALL NOT affect the current frame.
REQ-029 Latency: po_flag SHALL be asserted 4 clocks after the stop-bit strobe at most, counted from the rx pin, including the synchronizer.
REQ-030 A falling edge seen in STOP SHALL NOT be lost: the FSM returns to IDLE at mid-stop, leaving a half bit of margin for back-to-back frames.

Reset
REQ-031 While rst=1 the block SHALL force:
  - state IDLE; baud_cnt and bit_cnt = 0.
  - synchronizer flops = 1.
  - po_rx_data = 0; po_flag, po_parity_err, po_frame_err, po_break = 0.
REQ-032 A reset asserted mid-frame SHALL abort the frame with no po_flag.
  - Reception restarts only on a new falling edge after rst is released.

Verification (baud_rate_cnt=15, 16 clk/bit)
REQ-033 8N1, rx frame 0x A5 -> one po_flag; po_rx_data=0xA5; all errors 0.
REQ-034 7E1, data 0x35, parity bit 1 (wrong) -> po_rx_data=0x35, po_parity_err=1, po_frame_err=0.
REQ-035 5O2, data 0x1F, parity bit 0 -> po_rx_data=0x1F, po_parity_err=0; a back-to-back next frame 0x0A is received correctly.
REQ-036 Low glitch of 5 clocks on an idle line -> false start; no po_flag; state returns to IDLE.
REQ-037 8N1, rx held low for 20 bit times -> exactly one po_flag with po_break=1, po_frame_err=1, po_rx_data=0; no further po_flag until rx returns high and a new frame arrives.
REQ-038 rst pulsed during data bit 3 of an 8N1 frame -> no po_flag; all outputs 0; the next full frame 0x3C is received correctly.
